// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator datapath blocks.
// Holds opcode encodings and the execute-stage state encodings.
package rpn_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;

    // Execute-unit sequencer states
    localparam logic [2:0] EX_IDLE  = 3'd0;
    localparam logic [2:0] EX_RDB   = 3'd1;
    localparam logic [2:0] EX_RDA   = 3'd2;
    localparam logic [2:0] EX_LATA  = 3'd3;
    localparam logic [2:0] EX_EXEC  = 3'd4;
    localparam logic [2:0] EX_WRITE = 3'd5;
    localparam logic [2:0] EX_DONE  = 3'd6;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN execute stage.
// Computes A op B modulo 2^WIDTH and flags carry/borrow/high-product overflow.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                ovf    = sum[WIDTH];
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow (A < B)
                result = diff[WIDTH-1:0];
                ovf    = diff[WIDTH];
            end
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                ovf    = |prod[2*WIDTH-1:WIDTH];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rpn_exec_unit.sv
// Execute stage of the RPN calculator: pops two operands, applies the ALU op,
// pushes the result and hands the decremented SP back to the SP register.
module rpn_exec_unit
    import rpn_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] sp_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [ADDR_W-1:0] sp_out,
    output logic              sp_we,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              ovf
);

    logic [2:0]        state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] sp_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_ovf;

    rpn_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .ovf    (alu_ovf)
    );

    // All outputs are registered and set one edge ahead of the state they belong to,
    // so nothing combinational reaches an output from start.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= EX_IDLE;
            op_q      <= '0;
            sp_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            sp_out    <= '0;
            sp_we     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                EX_IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        ovf   <= 1'b0;
                        op_q  <= op;
                        sp_q  <= sp_in;
                        if (sp_in < ADDR_W'(2) || op > OP_XOR) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= EX_DONE;
                        end else begin
                            busy     <= 1'b1;
                            mem_addr <= sp_in - ADDR_W'(1);
                            state    <= EX_RDB;
                        end
                    end
                end
                EX_RDB: begin
                    mem_addr <= sp_q - ADDR_W'(2);
                    state    <= EX_RDA;
                end
                EX_RDA: begin
                    b_q   <= mem_rdata;
                    state <= EX_LATA;
                end
                EX_LATA: begin
                    a_q   <= mem_rdata;
                    state <= EX_EXEC;
                end
                EX_EXEC: begin
                    // mem_addr still holds sp-2 from RDB, which is the write slot
                    mem_wdata <= alu_result;
                    ovf       <= alu_ovf;
                    mem_we    <= 1'b1;
                    sp_out    <= sp_q - ADDR_W'(1);
                    sp_we     <= 1'b1;
                    state     <= EX_WRITE;
                end
                EX_WRITE: begin
                    mem_we <= 1'b0;
                    sp_we  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= EX_DONE;
                end
                EX_DONE: begin
                    done  <= 1'b0;
                    state <= EX_IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    sp_we  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    state  <= EX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rpn_exec_unit.md
# rpn_exec_unit

Execute stage of the RPN calculator, downstream of the push/stack-pointer controller. On a `start` pulse it pops the two top operands from the stack RAM and applies the selected arithmetic/logic operation. It then pushes the result back and hands the decremented stack pointer to the stack-pointer register. It shares the single-port synchronous stack RAM and SP register with the push controller, which must not drive them while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 8, data width of stack entries and result
- `ADDR_W`, 8, stack address / stack pointer width

Ports:
- `CLOCK_50`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request one operation; sampled only in IDLE
- `op`  in  3  opcode, sampled with `start`: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR; 6–7 illegal
- `sp_in`  in  ADDR_W  current SP (next free slot; top of stack at `sp_in-1`), sampled with `start`
- `mem_addr`  out  ADDR_W  stack RAM address
- `mem_wdata`  out  WIDTH  stack RAM write data
- `mem_we`  out  1  stack RAM write enable
- `mem_rdata`  in  WIDTH  stack RAM read data; valid the cycle after `mem_addr` is presented
- `sp_out`  out  ADDR_W  new SP value
- `sp_we`  out  1  SP register load enable (one cycle)
- `busy`  out  1  high from the first cycle after an accepted `start` through WRITE
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  last operation rejected (underflow or illegal op); held until next accepted `start`
- `ovf`  out  1  last result overflowed WIDTH; held until next accepted `start`

## Operation
- Operand order: A = entry at `sp-2` (deeper), B = entry at `sp-1` (top). SUB computes A−B; "3 4 −" gives −1.
- States, one cycle each unless noted:
  - IDLE: waits for `start`.
  - RDB: `mem_addr`=sp−1.
  - RDA: `mem_addr`=sp−2; latch B from `mem_rdata`.
  - LATA: latch A.
  - EXEC: register result and ovf.
  - WRITE: `mem_addr`=sp−2, `mem_wdata`=result, `mem_we`=1, `sp_out`=sp−1, `sp_we`=1.
  - DONE: `done`=1, then IDLE.
- On `start` in IDLE:
  - Clear `error`/`ovf` and capture `op`/`sp_in`.
  - If `sp_in` < 2 or `op` ≥ 6: go to DONE with `error`=1. No RAM write and no `sp_we`.
  - Otherwise go to RDB.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: `ovf` = carry out.
  - SUB: `ovf` = borrow (A<B).
  - MUL: result is the low WIDTH bits of the 2·WIDTH product; `ovf` = high half nonzero.
  - Logic ops: `ovf`=0.
- `start` while not in IDLE (including DONE) is ignored; no queuing.
- `sp_in` changes after capture are ignored.

## Timing
- Reset values: state IDLE; `mem_addr`, `mem_wdata`, `sp_out` = 0; `mem_we`, `sp_we`, `busy`, `done`, `error`, `ovf` = 0.
- All outputs are registered or decoded from state only; there is no combinational path from `start` to any output.
- Valid op, `start` sampled at edge E0:
  - RDB occupies E0–E1.
  - WRITE occupies E4–E5; RAM and SP update at E5.
  - `done` is high E5–E6. Latency is 6 cycles start-to-done.
- Rejected op: `done` is high E0–E1 (1 cycle), `busy` never rises.
- `mem_we` and `sp_we` are high only in WRITE, exactly one cycle, and always together.
- Reset asserted in any state returns to IDLE at the next edge.
  - If asserted during WRITE, the edge still completes that cycle's RAM/SP write.
  - If asserted before WRITE, no write occurs.
- Back-to-back: a `start` held high through DONE is accepted in the following IDLE cycle (E6), giving 7-cycle throughput.

## Structure
- Shared package `rpn_pkg`:
  - opcode constants (`OP_ADD`…`OP_XOR`)
  - state encodings for this block, alongside the existing push-controller state definitions
  - seven-segment constants stay where they are
- One sub-module, `rpn_alu`: combinational, parameter WIDTH; inputs A, B, op; outputs result and ovf. The result/ovf register stays in `rpn_exec_unit`.
- RAM, SP register and arbitration with the push controller are outside this block.

## Test plan
- RAM[0]=3, RAM[1]=4, `sp_in`=2, ADD
  - RAM[0]=7, `sp_out`=1 with `sp_we` for one cycle
  - `done` 6 cycles after start; `ovf`=0, `error`=0; RAM[1] unchanged
- Same stack, SUB → RAM[0]=0xFF, `ovf`=1.
- RAM[4]=0x20, RAM[5]=0x10, `sp_in`=6, MUL → RAM[4]=0x00, `ovf`=1, `sp_out`=5. Repeat with 0x0F×0x11 → 0xFF, `ovf`=0.
- Rejected operations:
  - `sp_in`=1, ADD → `done` the cycle after start, `error`=1, no `mem_we`/`sp_we`, `busy` stays 0.
  - `sp_in`=5, `op`=7 → same response.
- Reset and ignored start:
  - Pulse `reset` in EXEC → IDLE next cycle, all outputs 0, no RAM write.
  - Separately, pulse `start` during LATA → ignored; exactly one `done`.
- Back-to-back ops: 3 4 5 stack (`sp_in`=3), ADD then ADD with updated SP fed back → RAM[0]=12, final SP=1, two `done` pulses 7 cycles apart.
